// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Imported by the loader top and its byte packer.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Stream is accepted in every non-terminal state.
    function automatic logic state_accepts(loader_state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) ||
               (s == S_DATA)   || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream valid/ready handshake feeding the program loader.
// master = byte source, slave = loader.
interface program_loader_if;

    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready
    );

endinterface

// File: rtl/program_loader_packer.sv
// Big-endian byte-to-word packer: MSB-first shift, 2-bit lane.
// word_done pulses combinationally on the 4th byte of each word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word
);

    logic [23:0] shreg;
    logic [1:0]  lane;

    assign word_done = byte_valid && (lane == 2'd3);
    assign word      = {shreg, byte_in};

    // Shift accepted bytes in; lane wraps 3 -> 0 after a word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg <= 24'd0;
            lane  <= 2'd0;
        end else if (byte_valid) begin
            shreg <= {shreg[15:0], byte_in};
            lane  <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses length header, writes packed words to imem,
// verifies XOR checksum, then releases the core or flags an error.
import loader_pkg::*;

module program_loader #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    program_loader_if.slave       in_if,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [DEPTH_LOG2:0]   words_loaded,
    output logic                  cpu_run,
    output logic                  err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH_LOG2;

    loader_state_t state;
    logic [7:0]    len_hi;
    logic [15:0]   len_q;
    logic [7:0]    xor_q;

    logic          fire;
    logic [15:0]   n_rx;
    logic [16:0]   idx_ext;
    logic          pk_valid;
    logic          pk_clr;
    logic          pk_done;
    logic [31:0]   pk_word;

    assign in_if.in_ready = state_accepts(state);
    assign fire     = in_if.in_valid && in_if.in_ready;
    assign n_rx     = {len_hi, in_if.in_byte};
    assign idx_ext  = 17'(words_loaded);
    assign pk_valid = fire && (state == S_DATA);
    assign pk_clr   = fire && (state == S_LEN_LO);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr),
        .byte_valid (pk_valid),
        .byte_in    (in_if.in_byte),
        .word_done  (pk_done),
        .word       (pk_word)
    );

    // Load FSM with counters, checksum and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LEN_HI;
            len_hi       <= 8'd0;
            len_q        <= 16'd0;
            xor_q        <= 8'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            words_loaded <= '0;
            cpu_run      <= 1'b0;
            err          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                S_LEN_HI: begin
                    if (fire) begin
                        len_hi <= in_if.in_byte;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (fire) begin
                        len_q <= n_rx;
                        if (n_rx == 16'd0) begin
                            state <= S_CSUM;
                        end else if ({1'b0, n_rx} > MAX_WORDS) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        xor_q <= xor_q ^ in_if.in_byte;
                        if (pk_done) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= pk_word;
                            imem_addr  <= BASE_ADDR +
                                32'(idx_ext) * 32'(WORD_BYTES);
                            if ({1'b0, len_q} > idx_ext)
                                words_loaded <= words_loaded + 1'b1;
                            if (idx_ext + 17'd1 >= {1'b0, len_q})
                                state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (fire) begin
                        if (in_if.in_byte == xor_q) begin
                            state   <= S_RUN;
                            cpu_run <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_RUN, S_ERR: begin
                    state <= state;
                end
                default: begin
                    state <= S_ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: image-level reference model
// predicts word writes and final outcome; monitor checks strobes.
module tb_program_loader;

    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1 << D;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic [D:0]    words_loaded;
    logic          cpu_run;
    logic          err;

    program_loader_if bus ();

    program_loader #(
        .DEPTH_LOG2 (D),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_if        (bus.slave),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .words_loaded (words_loaded),
        .cpu_run      (cpu_run),
        .err          (err)
    );

    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next predicted write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e.a);
                check("wr_data", imem_wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        ok = 1'b0;
        for (int t = 0; t < 8 && !ok; t++) begin
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, BASE);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_run", 32'(cpu_run), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
    endtask

    // Model from stream rules, then drive and check the outcome.
    task automatic load_and_check(input bq_t img, input int gap_max,
                                  input int stall_at, input int stall_len);
        int         n;
        int         nsend;
        logic [7:0] x;
        logic       good;
        logic       over;
        wr_t        w;
        n    = {img[0], img[1]};
        over = (n > MAXW);
        x    = 8'h00;
        if (over) begin
            nsend = 2;
            good  = 1'b0;
        end else begin
            nsend = 4 * n + 3;
            for (int i = 0; i < n; i++) begin
                w.a = BASE + 32'(4 * i);
                w.d = {img[2 + 4 * i], img[3 + 4 * i],
                       img[4 + 4 * i], img[5 + 4 * i]};
                exp_q.push_back(w);
                for (int k = 0; k < 4; k++)
                    x = x ^ img[2 + 4 * i + k];
            end
            good = (img[nsend - 1] == x);
        end
        for (int i = 0; i < nsend; i++) begin
            int g;
            g = (i == stall_at) ? stall_len :
                (gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
            if (i == nsend - 1) begin
                check("pre_run", 32'(cpu_run), 32'd0);
                check("pre_err", 32'(err), 32'd0);
            end
            send_byte(img[i], g);
        end
        check("run", 32'(cpu_run), 32'(good));
        check("err", 32'(err), 32'(!good));
        check("ready_low", 32'(bus.in_ready), 32'd0);
        check("words", 32'(words_loaded), over ? 32'd0 : 32'(n));
        check("writes_done", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check("run_sticky", 32'(cpu_run), 32'(good));
        check("we_idle", 32'(imem_we), 32'd0);
        exp_q.delete();
    endtask

    function automatic bq_t rand_image();
        bq_t        q;
        int         n;
        int         sel;
        logic [7:0] x;
        logic [7:0] b;
        sel = $urandom_range(0, 9);
        if (sel == 0)
            n = $urandom_range(MAXW + 1, 300);
        else if (sel == 1)
            n = MAXW;
        else
            n = $urandom_range(0, MAXW);
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        x = 8'h00;
        if (n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                q.push_back(b);
            end
            if ($urandom_range(0, 3) == 0)
                x = x ^ 8'($urandom_range(1, 255));
            q.push_back(x);
        end
        return q;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t good_img;
        bq_t img;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        good_img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                     8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        load_and_check(good_img, 0, -1, 0);
        do_reset();

        img = good_img;
        img[10] = 8'h09;
        load_and_check(img, 0, -1, 0);
        do_reset();

        img[10] = 8'h08;
        load_and_check(img, 0, -1, 0);
        do_reset();

        img = '{8'h00, 8'h00, 8'h00};
        load_and_check(img, 0, -1, 0);
        do_reset();

        img = '{8'h00, 8'h11};
        load_and_check(img, 0, -1, 0);
        do_reset();

        img = '{8'h01, 8'h00};
        load_and_check(img, 0, -1, 0);
        do_reset();

        load_and_check(good_img, 0, 4, 5);
        do_reset();

        for (int i = 0; i < 5; i++)
            send_byte(good_img[i], 0);
        do_reset();
        load_and_check(good_img, 0, -1, 0);
        do_reset();

        for (int r = 0; r < 25; r++) begin
            img = rand_image();
            load_and_check(img, $urandom_range(0, 2), -1, 0);
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
